// File: rtl/eth_tx_frame_stream_if.sv
// eth_tx_frame_stream_if: payload byte handshake into the ETH transmit framer.
// The source (packet FIFO side) uses the master modport, the framer the slave modport.
interface eth_tx_frame_stream_if;
  logic       IN_VALID;
  logic [7:0] IN_DATA;
  logic       IN_LAST;
  logic       IN_READY;

  modport master (
    output IN_VALID,
    output IN_DATA,
    output IN_LAST,
    input  IN_READY
  );

  modport slave (
    input  IN_VALID,
    input  IN_DATA,
    input  IN_LAST,
    output IN_READY
  );
endinterface

// File: rtl/eth_tx_frame_stream.sv
// eth_tx_frame_stream: transmit framer for the 10-bit {CKE, FRM, DAT} ETH stream.
// Wraps payload bytes with preamble/SFD, a fixed Ethernet header, optional
// minimum-length padding and the IEEE 802.3 FCS, then holds the inter-frame gap.
// One byte slot per cycle with TICK=1; output is registered.
// Optional feature macro: ETH_TX_PAD_EN (zero-pad short payloads to a 64-byte frame).
module eth_tx_frame_stream #(
  parameter logic [47:0] DST_MAC   = 48'h00_21_70_9D_2D_4D,
  parameter logic [47:0] SRC_MAC   = 48'h00_50_C2_AE_40_01,
  parameter logic [15:0] ETH_TYPE  = 16'h88B5,
  parameter int unsigned IFG_BYTES = 12
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        TICK,
  eth_tx_frame_stream_if.slave        in_bus,
  output logic                        BUSY,
  output logic                        ERR,
  output logic [9:0]                  OUT_ETH_STREAM
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_HDR  = 3'd2;
  localparam logic [2:0] ST_PAY  = 3'd3;
`ifdef ETH_TX_PAD_EN
  localparam logic [2:0]  ST_PAD  = 3'd4;
  localparam logic [10:0] MIN_PAY = 11'd46;
`endif
  localparam logic [2:0] ST_FCS  = 3'd5;
  localparam logic [2:0] ST_IFG  = 3'd6;

  localparam logic [10:0]  MAX_PAY  = 11'd1500;
  localparam logic [15:0]  IFG_LAST = 16'(IFG_BYTES - 1);
  localparam logic [111:0] HDR_VEC  = {DST_MAC, SRC_MAC, ETH_TYPE};

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [10:0] pay_cnt_q, pay_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        abort_q, abort_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [9:0]  out_q, out_d;

  logic        tx_frm;
  logic [7:0]  tx_dat;
  logic [10:0] pay_next;
  logic [31:0] fcs_word;
  logic [7:0]  fcs_byte;
  logic [7:0]  hdr_rom [14];

  // Header bytes, most significant byte of DST_MAC first.
  for (genvar gi = 0; gi < 14; gi++) begin : g_hdr
    assign hdr_rom[gi] = HDR_VEC[111 - 8*gi -: 8];
  end

  // Reflected CRC-32 (0xEDB88320 is 0x04C11DB7 bit-reversed), one byte per call.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // Payload counter saturates so an oversize stream never wraps it.
  assign pay_next = (pay_cnt_q == MAX_PAY) ? MAX_PAY : pay_cnt_q + 11'd1;

  // Ready only on a payload slot; no byte is taken between ticks.
  assign in_bus.IN_READY = (state_q == ST_PAY) && TICK;

  // FCS byte select: complemented CRC sent LSB first; an aborted frame sends it inverted.
  always_comb begin
    fcs_word = abort_q ? crc_q : ~crc_q;
    case (cnt_q[1:0])
      2'd0:    fcs_byte = fcs_word[7:0];
      2'd1:    fcs_byte = fcs_word[15:8];
      2'd2:    fcs_byte = fcs_word[23:16];
      default: fcs_byte = fcs_word[31:24];
    endcase
  end

  // Frame sequencer: every decision and output byte happens on a TICK cycle only.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pay_cnt_d = pay_cnt_q;
    crc_d     = crc_q;
    abort_d   = abort_q;
    busy_d    = busy_q;
    err_d     = 1'b0;
    tx_frm    = 1'b0;
    tx_dat    = 8'h00;
    out_d     = {1'b0, out_q[8:0]};
    if (TICK) begin
      tx_frm = 1'b1;
      case (state_q)
        ST_IDLE: begin
          tx_frm = 1'b0;
          if (in_bus.IN_VALID) begin
            // The start tick already carries preamble byte 0.
            tx_frm    = 1'b1;
            tx_dat    = 8'h55;
            state_d   = ST_PRE;
            cnt_d     = 16'd1;
            busy_d    = 1'b1;
            crc_d     = 32'hFFFF_FFFF;
            abort_d   = 1'b0;
            pay_cnt_d = 11'd0;
          end
        end
        ST_PRE: begin
          tx_dat = (cnt_q == 16'd7) ? 8'hD5 : 8'h55;
          if (cnt_q == 16'd7) begin
            state_d = ST_HDR;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_HDR: begin
          tx_dat = hdr_rom[cnt_q[3:0]];
          crc_d  = crc_byte(crc_q, tx_dat);
          if (cnt_q == 16'd13) begin
            state_d = ST_PAY;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_PAY: begin
          cnt_d = 16'd0;
          if (in_bus.IN_VALID) begin
            tx_dat    = in_bus.IN_DATA;
            crc_d     = crc_byte(crc_q, tx_dat);
            pay_cnt_d = pay_next;
            if (in_bus.IN_LAST || (pay_next == MAX_PAY)) begin
              state_d = ST_FCS;
              if (!in_bus.IN_LAST) begin
                err_d   = 1'b1;
                abort_d = 1'b1;
              end
`ifdef ETH_TX_PAD_EN
              if (pay_next < MIN_PAY) begin
                state_d = ST_PAD;
              end
`endif
            end
          end else begin
            // Underrun: the slot still goes out (as 0x00) and is covered by the CRC.
            tx_dat  = 8'h00;
            crc_d   = crc_byte(crc_q, 8'h00);
            err_d   = 1'b1;
            abort_d = 1'b1;
            state_d = ST_FCS;
          end
        end
`ifdef ETH_TX_PAD_EN
        ST_PAD: begin
          tx_dat    = 8'h00;
          crc_d     = crc_byte(crc_q, 8'h00);
          pay_cnt_d = pay_next;
          if (pay_next >= MIN_PAY) begin
            state_d = ST_FCS;
            cnt_d   = 16'd0;
          end
        end
`endif
        ST_FCS: begin
          tx_dat = fcs_byte;
          if (cnt_q == 16'd3) begin
            state_d = ST_IFG;
            cnt_d   = 16'd0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_IFG: begin
          tx_frm = 1'b0;
          if (cnt_q == IFG_LAST) begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
            busy_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          tx_frm  = 1'b0;
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
          busy_d  = 1'b0;
        end
      endcase
      out_d = {1'b1, tx_frm, tx_dat};
    end
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      pay_cnt_q <= 11'd0;
      crc_q     <= 32'hFFFF_FFFF;
      abort_q   <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      out_q     <= 10'h000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pay_cnt_q <= pay_cnt_d;
      crc_q     <= crc_d;
      abort_q   <= abort_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
      out_q     <= out_d;
    end
  end

  assign BUSY           = busy_q;
  assign ERR            = err_q;
  assign OUT_ETH_STREAM = out_q;

endmodule
